// File: rtl/message_sequencer_if.sv
// Requester, ROM and serial_tx signals of the message sequencer.
// master = sequencer side, slave = requesters + ROM + transmitter side.
interface message_sequencer_if;
    logic [1:0] req;
    logic [1:0] grant;
    logic [1:0] done;
    logic       busy;
    logic [4:0] rom_addr;
    logic [7:0] rom_data;
    logic [7:0] tx_data;
    logic       tx_new_data;
    logic       tx_busy;
    logic       tx_block;

    modport master (
        input  req, rom_data, tx_busy, tx_block,
        output grant, done, busy, rom_addr, tx_data, tx_new_data
    );

    modport slave (
        output req, rom_data, tx_busy, tx_block,
        input  grant, done, busy, rom_addr, tx_data, tx_new_data
    );
endinterface

// File: rtl/message_sequencer.sv
// Round-robin sequencer streaming one ROM message at a time to serial_tx; 4 cycles/byte minimum.
// First strobe 4 edges after the req edge; stalls in SEND while tx_busy or tx_block is high.
module message_sequencer #(
    parameter int MSG_LEN = 14
) (
    input  logic                clk,
    input  logic                rst,
    message_sequencer_if.master bus
);
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] FETCH = 3'd1;
    localparam logic [2:0] LATCH = 3'd2;
    localparam logic [2:0] SEND  = 3'd3;
    localparam logic [2:0] GAP   = 3'd4;

    localparam logic [3:0] LAST_IDX = 4'(MSG_LEN - 1);

    logic [2:0] state_q, state_d;
    logic [1:0] pending_q, pending_d;
    logic [3:0] idx_q, idx_d;
    logic       bank_q, bank_d;
    logic       last_grant_q, last_grant_d;
    logic [7:0] tx_data_q, tx_data_d;
    logic       tx_new_data_q, tx_new_data_d;
    logic [1:0] grant_q, grant_d;
    logic [1:0] done_q, done_d;
    logic       win;

    always_comb begin
        state_d       = state_q;
        pending_d     = pending_q;
        idx_d         = idx_q;
        bank_d        = bank_q;
        last_grant_d  = last_grant_q;
        tx_data_d     = tx_data_q;
        tx_new_data_d = 1'b0;
        grant_d       = grant_q;
        done_d        = 2'b00;
        win           = 1'b0;

        case (state_q)
            IDLE: begin
                if (pending_q != 2'b00) begin
                    // With both pending, the requester not served last wins.
                    win            = (pending_q == 2'b11) ? ~last_grant_q : pending_q[1];
                    bank_d         = win;
                    idx_d          = 4'd0;
                    grant_d        = win ? 2'b10 : 2'b01;
                    last_grant_d   = win;
                    pending_d[win] = 1'b0;
                    state_d        = FETCH;
                end
            end
            FETCH: state_d = LATCH;
            LATCH: begin
                tx_data_d = bus.rom_data;
                state_d   = SEND;
            end
            SEND: begin
                if (!bus.tx_busy && !bus.tx_block) begin
                    tx_new_data_d = 1'b1;
                    state_d       = GAP;
                end
            end
            GAP: begin
                if (idx_q == LAST_IDX) begin
                    done_d  = bank_q ? 2'b10 : 2'b01;
                    grant_d = 2'b00;
                    state_d = IDLE;
                end else begin
                    idx_d   = idx_q + 4'd1;
                    state_d = FETCH;
                end
            end
            default: state_d = IDLE;
        endcase

        // A new request on the granting edge re-arms the flag, so the message replays.
        pending_d = pending_d | bus.req;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            pending_q     <= 2'b00;
            idx_q         <= 4'd0;
            bank_q        <= 1'b0;
            last_grant_q  <= 1'b1;
            tx_data_q     <= 8'h00;
            tx_new_data_q <= 1'b0;
            grant_q       <= 2'b00;
            done_q        <= 2'b00;
        end else begin
            state_q       <= state_d;
            pending_q     <= pending_d;
            idx_q         <= idx_d;
            bank_q        <= bank_d;
            last_grant_q  <= last_grant_d;
            tx_data_q     <= tx_data_d;
            tx_new_data_q <= tx_new_data_d;
            grant_q       <= grant_d;
            done_q        <= done_d;
        end
    end

    assign bus.rom_addr    = {bank_q, idx_q};
    assign bus.tx_data     = tx_data_q;
    assign bus.tx_new_data = tx_new_data_q;
    assign bus.grant       = grant_q;
    assign bus.done        = done_q;
    assign bus.busy        = (state_q != IDLE);
endmodule

// File: doc/message_sequencer.md
Name: message_sequencer

Overview:
- Arbitrates between two requesters for the shared message ROM (2 banks × 16 entries, 14 valid bytes per bank, 1-cycle registered read latency).
- Walks the granted bank's byte addresses and streams each byte to the serial transmitter through its new_data/busy/block handshake.
- Sits between the message sources (buttons, status logic) and the ROM + serial_tx pair.
- Strict round-robin arbitration; exactly one message is in flight at a time.

Parameters:
- MSG_LEN, 14, bytes sent per message; legal range 1..16; index is 4 bits.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- req  in  2  one-cycle request pulses; req[i] asks for bank i
- rom_addr  out  5  ROM address = {bank, idx[3:0]}
- rom_data  in  8  ROM read data, valid one cycle after rom_addr
- tx_data  out  8  byte to transmitter (registered)
- tx_new_data  out  1  one-cycle transmit strobe (registered)
- tx_busy  in  1  transmitter busy
- tx_block  in  1  transmitter flow-control hold
- grant  out  2  one-hot active requester; 00 when idle
- busy  out  1  high whenever state != IDLE
- done  out  2  one-cycle pulse on completion of requester i's message

Behaviour:
- Reset values (at the first edge with rst=1, from any state including mid-message):
  - state=IDLE, pending=00, idx=0, bank=0, last_grant=1.
  - tx_data=0x00, tx_new_data=0, grant=00, done=00, busy=0.
  - A partially sent message is abandoned and is not resumed.
- Pending flags:
  - req[i]=1 at an edge sets pending[i].
  - Repeated pulses while pending[i] is already set are not counted.
  - A req[i] arriving during service of bank i sets pending[i] again, so the message replays afterwards.
  - If req[i] and the grant of i fall on the same edge, the grant clears pending[i] and the new req sets it again; set wins.
- Arbitration (in IDLE only):
  - If exactly one pending bit is set, grant it.
  - If both are set, grant the index != last_grant.
  - On grant: bank<=i, idx<=0, grant<=onehot(i), last_grant<=i, clear pending[i], go to FETCH.
- FSM, one transition per edge unless noted:
  - IDLE → FETCH on a grant, else stay.
  - FETCH: rom_addr={bank,idx} (rom_addr is held constant from FETCH through GAP) → LATCH.
  - LATCH: tx_data<=rom_data → SEND.
  - SEND: if tx_busy=0 and tx_block=0, tx_new_data<=1 → GAP; otherwise stay. There is no timeout.
  - GAP: tx_new_data<=0.
    - If idx==MSG_LEN-1: done[bank]<=1 (one cycle), grant<=00 → IDLE.
    - Else idx<=idx+1 → FETCH.
- Timing:
  - Minimum 4 cycles per byte when the transmitter is free.
  - tx_new_data is never high on two consecutive cycles.
  - tx_data is stable for the full cycle that tx_new_data is high and until the next LATCH.
  - First tx_new_data is high in the cycle after the 4th edge following the edge that samples req (edges: IDLE→FETCH, →LATCH, →SEND, →GAP).
  - Back-to-back messages: IDLE lasts at least one cycle between messages, and done and the next grant never coincide.
- idx never exceeds MSG_LEN-1. ROM entries 14/15 of each bank are never addressed with the default MSG_LEN.

Test Plan:
- Single message, bank 0:
  - Stimulus: pulse req=01 with tx_busy/tx_block held 0.
  - Required: 14 tx_new_data strobes with tx_data 0D 0A 20 2C 6F 20 57 6F 72 6C 64 21 0D 0A; strobes 4 cycles apart; first strobe 4 edges after the req edge.
  - Then done=01 for exactly one cycle, and grant=01 → 00.
- Bank 1 with backpressure:
  - Stimulus: pulse req=10; transmitter model asserts tx_busy for 10 cycles after each strobe; tx_block=1 for 20 cycles mid-message.
  - Required: bytes 0D 0A 20 2C 64 62 79 20 6E 6F 77 2E 0D 0A in order; no strobe while tx_busy or tx_block is high; no byte lost or duplicated.
- Arbitration:
  - Stimulus: req=11 on the same edge after reset.
  - Required: bank 0 served first (last_grant reset=1), then bank 1.
  - Repeat req=11: bank 0 first again, since last_grant=1 after bank 1.
  - Follow-up: issue req[0] and req[1] together while bank 0 is active. Required: bank 1 is served next, then bank 0.
- Replay / duplicate pulses:
  - Stimulus: 3 req=01 pulses during bank 0 transmission.
  - Required: exactly one replay, i.e. 28 strobes total and 2 done[0] pulses.
- Reset mid-message:
  - Stimulus: assert rst for 1 cycle after the 5th strobe, with pending[1] set.
  - Required: next cycle busy=0, grant=00, tx_new_data=0, no done pulse; pending cleared, so no further strobes without a new req.
- MSG_LEN=1 build:
  - Stimulus: req=10.
  - Required: a single strobe with tx_data=0x0D, then done=10.
